ref_row_fetcher: RTL

Reference-block row fetcher that sits directly upstream of the subpixel interpolation top level and drives its 120-bit `in_row` input. On a start command it reads a 15×15 luma reference block (8×8 output block plus 7 filter-tap margin) from a 64-bit word-addressed frame memory. It realigns each line to an arbitrary byte offset and presents one 15-pixel row per valid/ready handshake.

---
 rtl/interp_pkg.sv | 25 ++
 rtl/row_aligner.sv | 24 ++
 rtl/ref_row_fetcher.sv | 137 +++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interp_pkg
// Brief    : Shared widths and fetcher state encoding for the interpolation path.
// Revision : 1.0
// ============================================================================
package interp_pkg;

    localparam int PIX_W         = 8;
    localparam int ROW_PIX       = 15;
    localparam int ROW_W         = PIX_W * ROW_PIX;
    localparam int WORD_W        = 64;
    localparam int WORDS_PER_ROW = 3;
    // Highest byte offset (7) plus one row: the only part of a 3-word line a row can reach.
    localparam int ALIGN_IN_W    = ROW_W + 7 * PIX_W;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_EMIT = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/row_aligner.sv
`default_nettype none
// ============================================================================
// Module   : row_aligner
// Brief    : Combinational byte shifter picking a 15-pixel row out of three words.
// Revision : 1.0
// ============================================================================
module row_aligner
    import interp_pkg::*;
(
    input  logic [ALIGN_IN_W-1:0] i_words,
    input  logic [2:0]            i_off,
    output logic [ROW_W-1:0]      o_row
);

    logic [ROW_W-1:0] w_cand [8];

    for (genvar g = 0; g < 8; g++) begin : g_off
        assign w_cand[g] = i_words[g*PIX_W +: ROW_W];
    end

    assign o_row = w_cand[i_off];

endmodule
`default_nettype wire

// File: rtl/ref_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : ref_row_fetcher
// Brief    : Fetches a 15x15 luma reference block, one byte-aligned row per handshake.
// Revision : 1.0
// ============================================================================
module ref_row_fetcher
    import interp_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int ROWS     = 15,
    parameter int STRIDE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [STRIDE_W-1:0] stride,
    output logic                busy,
    output logic                done,
    output logic                mem_req,
    output logic [ADDR_W-4:0]   mem_addr,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic [ROW_W-1:0]    row_out,
    output logic                row_valid,
    input  logic                row_ready,
    output logic [3:0]          row_idx
);

    localparam int         WA_W       = ADDR_W - 3;
    localparam logic [1:0] c_ST_IDLE  = FS_IDLE;
    localparam logic [1:0] c_ST_REQ   = FS_REQ;
    localparam logic [1:0] c_ST_WAIT  = FS_WAIT;
    localparam logic [1:0] c_ST_EMIT  = FS_EMIT;
    localparam logic [3:0] c_LAST_ROW = 4'(ROWS - 1);
    localparam logic [1:0] c_LAST_K   = 2'(WORDS_PER_ROW - 1);

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_line_addr;
    logic [STRIDE_W-1:0] r_stride;
    logic [3:0]          r_row_cnt;
    logic [1:0]          r_word_k;
    logic [WORD_W-1:0]   r_w0;
    logic [WORD_W-1:0]   r_w1;
    logic [ROW_W-1:0]    r_row_out;
    logic                r_row_valid;
    logic                r_done;
    logic [ROW_W-1:0]    w_aligned;

    // The third word is aligned straight off the bus so the row register loads on its rvalid.
    row_aligner u_row_aligner (
        .i_words ({mem_rdata[ALIGN_IN_W-2*WORD_W-1:0], r_w1, r_w0}),
        .i_off   (r_line_addr[2:0]),
        .o_row   (w_aligned)
    );

    assign mem_req   = (r_state == c_ST_REQ);
    assign mem_addr  = r_line_addr[ADDR_W-1:3] + WA_W'(r_word_k);
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;
    assign row_out   = r_row_out;
    assign row_valid = r_row_valid;
    assign row_idx   = r_row_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_line_addr <= '0;
            r_stride    <= '0;
            r_row_cnt   <= '0;
            r_word_k    <= '0;
            r_w0        <= '0;
            r_w1        <= '0;
            r_row_out   <= '0;
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !r_done) begin
                        r_line_addr <= base_addr;
                        r_stride    <= stride;
                        r_row_cnt   <= '0;
                        r_word_k    <= '0;
                        r_state     <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (mem_ack) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_word_k == 2'd0) begin
                            r_w0 <= mem_rdata;
                        end
                        if (r_word_k == 2'd1) begin
                            r_w1 <= mem_rdata;
                        end
                        if (r_word_k < c_LAST_K) begin
                            r_word_k <= r_word_k + 2'd1;
                            r_state  <= c_ST_REQ;
                        end else begin
                            r_row_out   <= w_aligned;
                            r_row_valid <= 1'b1;
                            r_state     <= c_ST_EMIT;
                        end
                    end
                end
                c_ST_EMIT: begin
                    if (row_ready) begin
                        r_row_valid <= 1'b0;
                        if (r_row_cnt == c_LAST_ROW) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_row_cnt   <= r_row_cnt + 4'd1;
                            r_line_addr <= r_line_addr + ADDR_W'(r_stride);
                            r_word_k    <= '0;
                            r_state     <= c_ST_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
